mio_timer: RTL
==============

# mio_timer

Memory-mapped countdown timer on the MIO bus. It sources the CPU's `time_interrupt` input, which no other block drives. The CPU programs the block through `mio_bus` with word writes and combinational reads, using the same pattern as the seg and RAM slaves. A programmable prescaler divides `clk`. A 32-bit down-counter raises a pending flag on expiry, in one-shot or periodic mode. The interrupt line is the pending flag gated by an enable bit.

## Interface
- `PRESC_W`, default 16: prescaler width. Must be ≤16. Sets the size of the CTRL prescale field.
- `clk` in 1: system clock. Same domain as the `mio_bus` write strobe.
- `clrn` in 1: asynchronous, active-low reset.
- `timer_a` in 2: word select, taken from `mem_a[3:2]`.
- `d_t_timer` in 32: write data.
- `wtimer` in 1: write strobe, one cycle per bus write.
- `d_f_timer` out 32: read data. Combinational on `timer_a`.
- `time_interrupt` out 1: level interrupt to the CPU, equal to PEND & IE.

## Operation
Register map (word select):
- 0 CTRL
  - bit0 EN
  - bit1 RELOAD (1 = periodic)
  - bit2 IE
  - bits[16+PRESC_W-1:16] PRESC
  - All other bits read 0.
- 1 LOAD: 32-bit reload value.
- 2 COUNT
  - Read returns the live counter.
  - Write loads the counter directly.
- 3 STATUS
  - bit0 PEND. Writing 1 clears it; writing 0 has no effect.
  - All other bits read 0.

Prescaler:
- Counts 0..PRESC while EN=1, then wraps to 0.
- `tick` is asserted for one cycle when the prescaler equals PRESC.
- When PRESC=0, `tick` is asserted every cycle.
- While EN=0 the prescaler is held at 0.

Counter states:
- IDLE (EN=0): the counter holds its value.
- RUN (EN=1), on each `tick`:
  - If COUNT≠0: COUNT ← COUNT−1.
  - If COUNT=0 (expiry): PEND ← 1.
    - RELOAD=1: COUNT ← LOAD.
    - RELOAD=0: COUNT stays 0 and EN ← 0, returning to IDLE.

CTRL writes:
- A CTRL write with EN 0→1 gives COUNT ← LOAD and prescaler ← 0 (start).
- A CTRL write with EN 1→1 updates RELOAD, IE and PRESC only. The counter and prescaler continue.
- A CTRL write with EN→0 stops the timer immediately. COUNT is held.

Boundary rules:
- LOAD=0 with RELOAD=1: the timer expires on every tick.
- Expiry and a STATUS W1C in the same cycle: set wins, so PEND stays 1.
- COUNT write and a tick in the same cycle: the write wins, no decrement and no expiry.
- Start (EN 0→1) in the same cycle as a LOAD write: the new LOAD value is used.
- IE=0: PEND still sets. `time_interrupt` stays 0 until IE=1, then asserts immediately if PEND=1.
- Down-counter arithmetic is unsigned mod 2^32. Because expiry is detected at 0, there is no underflow.
- `clrn` low at any time, including mid-count: all registers go to 0, `time_interrupt`=0, `d_f_timer` reads 0 for every address.

## Timing
- Start on the edge of clock cycle 0, with LOAD=N and PRESC=P. The expiry tick occurs at cycle (N+1)(P+1)−1. PEND and `time_interrupt` are high from cycle (N+1)(P+1).
- Periodic mode: the interval between PEND set events is (N+1)(P+1) cycles.
- Register writes take effect on the clock edge where `wtimer`=1. A read issued on the next cycle returns the new value.
- `time_interrupt` is driven from registers only. It goes low the cycle after a W1C write or an IE-clearing write.
- No multi-cycle handshake: every write completes in one cycle and reads have zero wait states.

## Structure
- The shared package `mio_timer_pkg` holds:
  - Register offsets: CTRL=0, LOAD=1, COUNT=2, STATUS=3.
  - CTRL bit positions: EN, RELOAD, IE, PRESC_LSB=16.
  - STATUS PEND bit.
- One sub-module, `mio_timer_prescaler`:
  - Inputs: `clk`, `clrn`, `en`, `restart`, `presc`.
  - Output: `tick`.
- Address decode, register file, counter FSM and read mux stay in `mio_timer`.
- Top-level integration: `mio_bus` decodes the timer window, drives `wtimer`/`timer_a`, and muxes `d_f_timer`. `time_interrupt` replaces the undriven wire at the CPU.

## Test plan
- **Reset:** pulse `clrn` low mid-run with EN=1, COUNT=5 → all reads 0 and `time_interrupt`=0 within the low phase. The timer stays idle after release.
- **One-shot:**
  - Stimulus: LOAD=3, PRESC=1, CTRL=EN|IE.
  - `time_interrupt` rises exactly 8 cycles after the CTRL write.
  - Then EN reads 0 and COUNT reads 0.
  - STATUS←1 drops `time_interrupt` on the next cycle.
- **Periodic:** LOAD=2, PRESC=0, CTRL=EN|RELOAD|IE, clearing PEND each time it sets → PEND sets every 3 cycles; COUNT sequence 2,1,0,2,1,0.
- **Collision:** issue the STATUS W1C on the exact expiry-tick cycle → PEND remains 1. Separately, write COUNT=7 on a tick cycle → the next read is 7, not 6.
- **IE gating:** run a one-shot with IE=0 → PEND=1 and `time_interrupt`=0. Then write CTRL with IE=1 → `time_interrupt`=1 on the next cycle.
- **Live reconfiguration:** while running with PRESC=0, write CTRL=EN|IE with PRESC=3 → decrements slow to every 4 cycles with no restart (COUNT is not reloaded).

Source files
------------

// File: rtl/mio_timer_pkg.sv
// Shared register map and field positions for the MIO countdown timer.
package mio_timer_pkg;

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrLoad   = 2'd1;
  localparam logic [1:0] AddrCount  = 2'd2;
  localparam logic [1:0] AddrStatus = 2'd3;

  localparam int unsigned CtrlEnBit     = 0;
  localparam int unsigned CtrlReloadBit = 1;
  localparam int unsigned CtrlIeBit     = 2;
  localparam int unsigned CtrlPrescLsb  = 16;

  localparam int unsigned StatusPendBit = 0;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/mio_timer_prescaler.sv
// Clock prescaler: counts 0..presc while enabled and pulses tick on the terminal count.
module mio_timer_prescaler #(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               en,
  input  logic               restart,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  // >= keeps the divider from running the long way round if presc shrinks mid-count.
  assign tick = en && (cnt_q >= presc);

  always_comb begin
    cnt_d = cnt_q;
    if (!en || restart) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mio_timer.sv
// Memory-mapped 32-bit countdown timer with prescaler, one-shot/periodic modes and
// a pending flag gated onto the CPU time interrupt.
module mio_timer
  import mio_timer_pkg::*;
#(
  parameter int unsigned PRESC_W = 16
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [1:0]  timer_a,
  input  logic [31:0] d_t_timer,
  input  logic        wtimer,
  output logic [31:0] d_f_timer,
  output logic        time_interrupt
);

  timer_state_e       state_q, state_d;
  logic               reload_q, reload_d;
  logic               ie_q, ie_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [31:0]        load_q, load_d;
  logic [31:0]        count_q, count_d;
  logic               pend_q, pend_d;

  logic        wr_ctrl, wr_load, wr_count, wr_status;
  logic        stop;
  logic        tick;
  logic        restart;
  logic        expire;
  logic [31:0] load_eff;

  assign wr_ctrl   = wtimer && (timer_a == AddrCtrl);
  assign wr_load   = wtimer && (timer_a == AddrLoad);
  assign wr_count  = wtimer && (timer_a == AddrCount);
  assign wr_status = wtimer && (timer_a == AddrStatus);

  assign stop     = wr_ctrl && !d_t_timer[CtrlEnBit];
  assign load_eff = wr_load ? d_t_timer : load_q;

  mio_timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk     (clk),
    .clrn    (clrn),
    .en      (state_q == StRun),
    .restart (restart),
    .presc   (presc_q),
    .tick    (tick)
  );

  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    ie_d     = ie_q;
    presc_d  = presc_q;
    load_d   = load_q;
    count_d  = count_q;
    pend_d   = pend_q;
    restart  = 1'b0;
    expire   = 1'b0;

    // A COUNT write or a stop in the same cycle suppresses the tick entirely.
    if ((state_q == StRun) && tick && !wr_count && !stop) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        expire = 1'b1;
        if (reload_q) begin
          count_d = load_eff;
        end else begin
          state_d = StIdle;
        end
      end
    end

    if (wr_ctrl) begin
      reload_d = d_t_timer[CtrlReloadBit];
      ie_d     = d_t_timer[CtrlIeBit];
      presc_d  = d_t_timer[CtrlPrescLsb +: PRESC_W];
      if (!d_t_timer[CtrlEnBit]) begin
        state_d = StIdle;
      end else if (state_q == StIdle) begin
        state_d = StRun;
        count_d = load_eff;
        restart = 1'b1;
      end
    end

    if (wr_load) begin
      load_d = d_t_timer;
    end
    if (wr_count) begin
      count_d = d_t_timer;
    end

    // Set beats clear when expiry and W1C land together.
    if (wr_status && d_t_timer[StatusPendBit]) begin
      pend_d = 1'b0;
    end
    if (expire) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= StIdle;
      reload_q <= 1'b0;
      ie_q     <= 1'b0;
      presc_q  <= '0;
      load_q   <= 32'd0;
      count_q  <= 32'd0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      ie_q     <= ie_d;
      presc_q  <= presc_d;
      load_q   <= load_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    d_f_timer = 32'd0;
    unique case (timer_a)
      AddrCtrl: begin
        d_f_timer[CtrlEnBit]                 = (state_q == StRun);
        d_f_timer[CtrlReloadBit]             = reload_q;
        d_f_timer[CtrlIeBit]                 = ie_q;
        d_f_timer[CtrlPrescLsb +: PRESC_W]   = presc_q;
      end
      AddrLoad:   d_f_timer = load_q;
      AddrCount:  d_f_timer = count_q;
      AddrStatus: d_f_timer[StatusPendBit] = pend_q;
      default:    d_f_timer = 32'd0;
    endcase
  end

  assign time_interrupt = pend_q & ie_q;

endmodule
